// File: rtl/lab4_pkg.sv
// Shared constants, FSM state encoding and helpers for the lab4 round-robin arbiter.
package lab4_pkg;

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/lab4_4_rr_prio_enc.sv
// Round-robin winner selection: rotate req by ptr, then pick the lowest set rotated index.
module lab4_4_rr_prio_enc
    import lab4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] offset;

    always_comb begin
        rot    = '0;
        offset = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rot[i] = req[IDX_W'(ptr + IDX_W'(i))];
        end
        // Scan downward so the lowest set rotated index is the last one written.
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = IDX_W'(i);
            end
        end
        winner  = IDX_W'(ptr + offset);
        any_req = |req;
    end

endmodule

// File: rtl/lab4_4_rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Define LAB4_ARB_TIMEOUT_EN to build the MAX_HOLD forced-release timeout.
module lab4_4_rr_arbiter
    import lab4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] id_d;
    logic [N_REQ-1:0] grant_d;
    logic             valid_d;
    logic             timeout_d;
    logic [IDX_W-1:0] winner;
    logic             any_req;

`ifdef LAB4_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    lab4_4_rr_prio_enc u_prio_enc (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = grant_id;
        timeout_d = 1'b0;
`ifdef LAB4_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_BUSY;
                    id_d    = winner;
`ifdef LAB4_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!req[grant_id]) begin
                    state_d = ST_IDLE;
                    ptr_d   = IDX_W'(grant_id + 1'b1);
                    id_d    = '0;
                end
`ifdef LAB4_ARB_TIMEOUT_EN
                // hold_q counts completed BUSY cycles minus one.
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = ST_IDLE;
                    ptr_d     = IDX_W'(grant_id + 1'b1);
                    id_d      = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = HOLD_W'(hold_q + 1'b1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = '0;
            end
        endcase
        valid_d = (state_d == ST_BUSY);
        grant_d = valid_d ? idx_onehot(id_d) : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
`ifdef LAB4_ARB_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant       <= grant_d;
            grant_id    <= id_d;
            grant_valid <= valid_d;
            timeout     <= timeout_d;
`ifdef LAB4_ARB_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

endmodule

// File: doc/lab4_4_rr_arbiter.md
LAB4_4_RR_ARBITER -- requirements
Module: lab4_4_rr_arbiter

Interface
- REQ-001: Parameter MAX_HOLD, default 8, maximum consecutive BUSY cycles per grant (timeout build only).
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: req  input  4  request per requester; bit i set = requester i wants the resource.
- REQ-005: grant  output  4  registered one-hot grant; all-zero when no owner.
- REQ-006: grant_id  output  2  registered index of the current owner; 0 when grant_valid=0.
- REQ-007: grant_valid  output  1  registered; 1 exactly when grant is non-zero.
- REQ-008: timeout  output  1  registered one-cycle pulse on a forced release; constant 0 when TIMEOUT_EN is undefined.

Function
- REQ-009: FSM states are IDLE (no owner) and BUSY (one owner).
- REQ-010: IDLE with req=0000: remain IDLE; outputs stay zero.
- REQ-011: IDLE with any req bit set: pick a winner and enter BUSY; grant, grant_id and grant_valid assert on the next clock edge (1-cycle latency).
- REQ-012: Winner selection scans from index ptr upward with wrap-around (ptr, ptr+1, ..., ptr+3, mod 4); the first set bit wins.
- REQ-013: BUSY with req[grant_id]=1 and no timeout: hold grant unchanged; other requests are ignored.
- REQ-014: BUSY with req[grant_id]=0: return to IDLE; outputs clear on the next edge; ptr <= grant_id+1 mod 4.
- REQ-015: The arbiter issues no back-to-back grants; every release is followed by at least one IDLE cycle with grant_valid=0.
- REQ-016: Requests that assert and drop while in BUSY are not remembered.
- REQ-017: ptr is a 2-bit counter; wrap from 3 to 0 is natural modulo-4 arithmetic.
- REQ-018: At most one grant bit is set in any cycle.

Reset
- REQ-019: On rst=1 at a clock edge: state <= IDLE; ptr <= 0; hold counter <= 0; grant <= 0000; grant_id <= 0; grant_valid <= 0; timeout <= 0.
- REQ-020: Reset overrides every other event, including reset asserted mid-grant; the first grant after reset scans from index 0.

Configuration
- REQ-021: Macro LAB4_ARB_TIMEOUT_EN selects the timeout build.
- REQ-022: With LAB4_ARB_TIMEOUT_EN defined:
  - The hold counter counts BUSY cycles.
  - When the owner has held grant for MAX_HOLD cycles, force the arbiter to IDLE.
  - timeout pulses on the same edge that grant clears.
  - ptr <= grant_id+1, as for a normal release.
  - If the owner still requests, it competes normally from IDLE.
- REQ-023: Without LAB4_ARB_TIMEOUT_EN: no hold counter is built; timeout is tied to 0; a grant is held indefinitely.
- REQ-024: If the owner drops req in the same cycle the timeout fires, the release counts as normal and timeout stays 0.

Structure
- REQ-025: Shared package lab4_pkg holds N_REQ=4, the IDLE/BUSY state encoding, and the default MAX_HOLD constant.
- REQ-026: Sub-module lab4_4_rr_prio_enc performs winner selection.
  - Combinational: rotates req by ptr, then applies a 4-to-2 priority encoder (lowest rotated index wins).
  - Outputs winner index and an any-request flag.
- REQ-027: All outputs are driven from flops; default assignments in the combinational next-state logic prevent latches.

Verification
- REQ-028: Reset, then req=0100 -> one cycle later grant=0100, grant_id=2, grant_valid=1.
- REQ-029: ptr=0, req=1010 -> grant_id=1; release -> one IDLE cycle, then grant_id=3.
- REQ-030: req=1111 held, each owner drops req one cycle after its grant -> grant order 0,1,2,3,0 with a gap cycle between grants.
- REQ-031: rst asserted while grant=1000 -> next edge all outputs 0; with req=1111, first grant goes to requester 0.
- REQ-032: TIMEOUT_EN, MAX_HOLD=8, req=0011 held -> grant 0 for 8 cycles, timeout=1 for one cycle, IDLE, then grant_id=1.
- REQ-033: Without TIMEOUT_EN, req=0001 held for 100 cycles -> grant stays 0001 and timeout stays 0.
